// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between an instruction-fetch port and an EXE data port.
// Reads have a fixed one-cycle latency; a response that is not accepted is parked in a buffer.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        inst_rready,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  input  logic        data_rready,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;    // 1: data port owns the in-flight response
  logic [2:0]  starve_q, starve_d;
  logic [31:0] buf_q, buf_d;

  logic        owner_rready;
  logic        grantable;
  logic        inst_win;
  logic        data_win;
  logic        read_gnt;
  logic        resp_valid;
  logic [31:0] resp_data;

  always_comb begin
    owner_rready = owner_q ? data_rready : inst_rready;
    grantable    = resetn && ((state_q == IDLE) || ((state_q == BUSY) && owner_rready));
    inst_win     = grantable && inst_req && (!data_req || (starve_q == STARVE_LIM));
    data_win     = grantable && data_req && !inst_win;
    read_gnt     = inst_win || (data_win && (data_we == 4'b0000));

    inst_gnt   = inst_win;
    data_gnt   = data_win;
    sram_en    = inst_win || data_win;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_win) begin
      sram_addr = inst_addr;
    end else if (data_win) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end

    resp_valid  = (state_q != IDLE);
    resp_data   = (state_q == HOLD) ? buf_q : sram_rdata;
    inst_rvalid = resp_valid && !owner_q;
    data_rvalid = resp_valid && owner_q;
    inst_rdata  = inst_rvalid ? resp_data : '0;
    data_rdata  = data_rvalid ? resp_data : '0;

    state_d = state_q;
    buf_d   = buf_q;
    owner_d = read_gnt ? data_win : owner_q;
    case (state_q)
      IDLE: state_d = read_gnt ? BUSY : IDLE;
      BUSY: begin
        if (owner_rready) begin
          state_d = read_gnt ? BUSY : IDLE;
        end else begin
          buf_d   = sram_rdata;
          state_d = HOLD;
        end
      end
      HOLD:    state_d = owner_rready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase

    starve_d = starve_q;
    if (!inst_req || inst_win) begin
      starve_d = '0;
    end else if (data_win && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, corner-case sequences and randomized traffic,
// all checked against a response-slot model of the arbitration rules.
module tb_sram_arbiter;

  localparam int SM = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_gnt, inst_rvalid, inst_rready;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_gnt, data_rvalid, data_rready;
  logic [3:0]  data_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata), .inst_rready(inst_rready),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .data_rready(data_rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: at most one outstanding response; its age says whether the value
  // is still the live SRAM output (age 1) or the one seen at age 1.
  bit          m_pend;
  bit          m_own;
  int          m_age;
  logic [31:0] m_val;
  int          m_starve;

  logic        a_igt, a_dgt, a_en, a_irv, a_drv;
  logic [31:0] a_ird, a_drd;

  task automatic model_reset();
    m_pend = 0; m_own = 0; m_age = 0; m_val = '0; m_starve = 0;
  endtask

  task automatic step();
    bit          consumed, can, iw, dw;
    logic [31:0] e_rd;
    @(negedge clk);
    a_igt = inst_gnt; a_dgt = data_gnt; a_en = sram_en;
    a_irv = inst_rvalid; a_drv = data_rvalid; a_ird = inst_rdata; a_drd = data_rdata;
    if (!resetn) begin
      chk_b("rst_inst_gnt", inst_gnt, 1'b0);
      chk_b("rst_data_gnt", data_gnt, 1'b0);
      chk_b("rst_sram_en", sram_en, 1'b0);
      chk_w("rst_sram_we", 32'(sram_we), '0);
      chk_b("rst_inst_rvalid", inst_rvalid, 1'b0);
      chk_b("rst_data_rvalid", data_rvalid, 1'b0);
      model_reset();
    end else begin
      consumed = m_pend && (m_own ? data_rready : inst_rready);
      can      = !m_pend || (consumed && m_age == 1);
      iw       = can && inst_req && (!data_req || m_starve == SM);
      dw       = can && data_req && !iw;
      e_rd     = (m_age == 1) ? sram_rdata : m_val;
      chk_b("inst_gnt", inst_gnt, iw);
      chk_b("data_gnt", data_gnt, dw);
      chk_b("sram_en", sram_en, iw || dw);
      chk_w("sram_we", 32'(sram_we), dw ? 32'(data_we) : '0);
      chk_w("sram_addr", sram_addr, iw ? inst_addr : (dw ? data_addr : '0));
      chk_w("sram_wdata", sram_wdata, dw ? data_wdata : '0);
      chk_b("inst_rvalid", inst_rvalid, m_pend && !m_own);
      chk_w("inst_rdata", inst_rdata, (m_pend && !m_own) ? e_rd : '0);
      chk_b("data_rvalid", data_rvalid, m_pend && m_own);
      chk_w("data_rdata", data_rdata, (m_pend && m_own) ? e_rd : '0);
      if (m_pend) begin
        if (consumed) m_pend = 0;
        else begin
          if (m_age == 1) m_val = sram_rdata;
          m_age++;
        end
      end
      if (iw || (dw && data_we == 4'b0000)) begin
        m_pend = 1; m_own = dw; m_age = 1;
      end
      if (!inst_req || iw) m_starve = 0;
      else if (dw && m_starve < SM) m_starve++;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdat;
    logic        e_igt;
    logic        e_dgt;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_irv;
    logic        e_drv;
  } vec_t;

  vec_t tbl[6];
  bit   cont_d[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h1C00_0000, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFE_0001,
               1'b1, 1'b0, 4'h0, 32'h1C00_0000, 32'h0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD, 32'h1111_2222,
               1'b0, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 32'h1357_2468,
               1'b0, 1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'h300, 1'b1, 4'h0, 32'h400, 32'h0, 32'h0BAD_F00D,
               1'b0, 1'b1, 4'h0, 32'h400, 32'h0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'hDEAD_0000, 1'b0, 4'hF, 32'hBEEF_0000, 32'h1111_1111, 32'h7777_7777,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h600, 1'b1, 4'hF, 32'h500, 32'h5555_AAAA, 32'h9999_8888,
               1'b0, 1'b1, 4'hF, 32'h500, 32'h5555_AAAA, 1'b0, 1'b0};
    cont_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h10; inst_rready = 1'b1;
    data_req = 1'b1; data_we = '0; data_addr = 32'h20; data_wdata = '0; data_rready = 1'b1;
    sram_rdata = 32'h5A5A_5A5A;
    model_reset();
    step();
    resetn = 1'b1;
    inst_req = 1'b0; data_req = 1'b0;
    step();

    // Single-transaction vectors, each started from an idle arbiter
    for (int i = 0; i < 6; i++) begin
      inst_req = tbl[i].ireq; inst_addr = tbl[i].iaddr;
      data_req = tbl[i].dreq; data_we = tbl[i].dwe;
      data_addr = tbl[i].daddr; data_wdata = tbl[i].dwdata;
      step();
      chk_b("tbl_inst_gnt", a_igt, tbl[i].e_igt);
      chk_b("tbl_data_gnt", a_dgt, tbl[i].e_dgt);
      chk_w("tbl_sram_we", 32'(sram_we), 32'(tbl[i].e_we));
      inst_req = 1'b0; data_req = 1'b0;
      sram_rdata = tbl[i].rdat;
      step();
      chk_b("tbl_inst_rvalid", a_irv, tbl[i].e_irv);
      chk_b("tbl_data_rvalid", a_drv, tbl[i].e_drv);
      chk_w("tbl_inst_rdata", a_ird, tbl[i].e_irv ? tbl[i].rdat : '0);
      chk_w("tbl_data_rdata", a_drd, tbl[i].e_drv ? tbl[i].rdat : '0);
    end

    // Contention: d, d, i, d, d, i
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_we = '0; data_addr = 32'h2000; data_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      sram_rdata = 32'hC000_0000 + 32'(i);
      step();
      chk_b("cont_data_gnt", a_dgt, cont_d[i]);
      chk_b("cont_inst_gnt", a_igt, !cont_d[i]);
      if (i > 0) chk_b("cont_one_resp", a_irv ^ a_drv, 1'b1);
    end
    inst_req = 1'b0; data_req = 1'b0;
    step();

    // Backpressure on a data read
    data_req = 1'b1; data_we = '0; data_addr = 32'h40; data_rready = 1'b0;
    step();
    chk_b("bp_first_gnt", a_dgt, 1'b1);
    for (int k = 0; k < 3; k++) begin
      sram_rdata = 32'hB000_0000 + 32'(k);
      step();
      chk_b("bp_rvalid", a_drv, 1'b1);
      chk_w("bp_rdata", a_drd, 32'hB000_0000);
      chk_b("bp_no_gnt", a_dgt, 1'b0);
      chk_b("bp_no_en", a_en, 1'b0);
    end
    data_rready = 1'b1; sram_rdata = 32'hFFFF_0000;
    step();
    chk_w("bp_release_rdata", a_drd, 32'hB000_0000);
    chk_b("bp_release_no_gnt", a_dgt, 1'b0);
    step();
    chk_b("bp_resume_gnt", a_dgt, 1'b1);
    data_req = 1'b0;
    step();

    // Back-to-back reads, no bubble
    data_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) data_req = 1'b0;
      data_addr = 32'h80 + 32'(4 * i);
      sram_rdata = 32'hD000_0000 + 32'(i);
      step();
      chk_b("b2b_gnt", a_dgt, i < 3);
      chk_b("b2b_rvalid", a_drv, i > 0);
    end
    step();
    chk_b("b2b_drained", a_drv, 1'b0);

    // Reset while holding a response, starve count built up beforehand
    inst_req = 1'b1; inst_addr = 32'h3000; data_req = 1'b1; data_addr = 32'h4000;
    step();
    step();
    data_rready = 1'b0;
    step();
    step();
    chk_b("rh_in_hold", a_drv, 1'b1);
    resetn = 1'b0;
    #1;
    chk_b("rh_rvalid_drop", data_rvalid, 1'b0);
    chk_b("rh_no_en", sram_en, 1'b0);
    model_reset();
    #2;
    resetn = 1'b1;
    step();
    chk_b("rh_after_data_gnt", a_dgt, 1'b1);
    chk_b("rh_after_inst_gnt", a_igt, 1'b0);
    chk_b("rh_after_no_rvalid", a_drv | a_irv, 1'b0);
    data_rready = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    step();
    step();

    // Randomized traffic; an ungranted requester keeps its fields
    for (int n = 0; n < 600; n++) begin
      inst_rready = ($urandom_range(0, 3) != 0);
      data_rready = ($urandom_range(0, 3) != 0);
      sram_rdata  = $urandom;
      step();
      if (!inst_req || a_igt) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req || a_dgt) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
